register_file_sb: RTL
=====================

// Module: register_file_sb
// PURPOSE
// - Parametrised successor of the decode-stage integer register file: N combinational read ports, 1 write port,
//   hardwired-zero register 0, per-register busy scoreboard for hazard detection, sequential clear sweep after reset.
// - Sits in Decode: reads source operands, takes writeback (ResultW/RdW), exposes busy bits to the hazard unit.
// PARAMETERS
// - WIDTH     32  data width in bits
// - DEPTH     32  number of registers, power of 2, >= 4; ADDR_W = $clog2(DEPTH) is a localparam
// - NUM_READ  2   number of read ports, 1..4
// PORTS
// - clk                  in   1                 single clock; all state updates on posedge
// - rst                  in   1                 synchronous reset, active-high
// - WriteEnable          in   1                 write strobe (WE3)
// - RegisterDestination  in   ADDR_W            write address (A3)
// - WriteData            in   WIDTH             write data (WD3)
// - ReadRegisters        in   NUM_READ*ADDR_W   read addresses; port i at [i*ADDR_W +: ADDR_W]
// - ReadData             out  NUM_READ*WIDTH    read data; port i at [i*WIDTH +: WIDTH]
// - ReadBusy             out  NUM_READ          1 = register on port i has a pending write
// - AllocEnable          in   1                 decode issued an instruction that will write AllocRegister
// - AllocRegister        in   ADDR_W            register to mark busy
// - Ready                out  1                 1 = clear sweep done, file usable
// BEHAVIOUR
// - FSM: CLEAR, READY. rst=1 at posedge -> CLEAR, ClearPtr=1, all busy bits=0, Ready=0 (from next cycle).
// - CLEAR, rst=0: each posedge writes 0 to mem[ClearPtr], ClearPtr++; on the posedge clearing DEPTH-1 -> READY.
//   Ready rises exactly DEPTH-1 cycles after the first rst=0 posedge (31 for DEPTH=32).
// - rst mid-sweep: ClearPtr returns to 1, sweep restarts from scratch; no partial completion.
// - In CLEAR: WriteEnable and AllocEnable ignored; ReadData all 0; ReadBusy all 0.
// - Reads: combinational, zero latency. Address 0 always returns 0 and ReadBusy=0.
// - Write (READY): posedge, WriteEnable=1 and RegisterDestination!=0 -> mem[dst] <= WriteData. Writes to 0 dropped.
// - Same-cycle read of the register being written returns the OLD value (write visible next cycle) unless bypass.
// - Scoreboard (READY): AllocEnable & AllocRegister!=0 sets busy[AllocRegister]; WriteEnable clears busy[dst].
//   Same reg allocated and written in one cycle: alloc wins, busy stays 1 (newer producer outstanding).
//   Writes to a non-busy register are legal; data is stored, busy stays 0.
// - ReadBusy[i] = busy[ReadRegisters[i]], combinational.
// - All registers 0 after reset sweep; register 0 never stored (no flop).
// CONFIGURATION
// - REGFILE_BYPASS_EN defined: read port whose address equals RegisterDestination with WriteEnable=1, addr!=0 and
//   state READY returns WriteData combinationally, and its ReadBusy is 0 unless the same cycle re-allocates it.
// - Not defined: no forwarding; old value returned that cycle, ReadBusy reflects the pre-update busy bit.
// TESTING
// - rst 1 cycle then low, DEPTH=32 -> Ready=0 for 31 cycles, 1 on 32nd; all reads 0; writes during sweep lost.
// - rst reasserted at sweep cycle 10 -> Ready rises 31 cycles after the second release, mem[1..31]=0.
// - Write x5=0xDEADBEEF, next cycle read x5 on port 0 and x5 on port 1 -> both 0xDEADBEEF; write x0=0x1234 -> x0 reads 0.
// - Alloc x7; read x7 -> ReadBusy=1; writeback x7=0x55 -> next cycle busy=0, data 0x55; alloc+write x7 same cycle -> busy=1.
// - Same-cycle write x9=0xA5A5A5A5 and read x9: with REGFILE_BYPASS_EN -> 0xA5A5A5A5; without -> prior value 0.
// - NUM_READ=3, DEPTH=16, WIDTH=64: write x15=64'hFFFF_0000_FFFF_0000 -> all three ports read it; sweep takes 15 cycles.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb
// Decode-stage integer register file with NUM_READ combinational read ports,
// one write port, hardwired-zero register 0 and a per-register busy
// scoreboard for the hazard unit. After reset the file is swept to zero one
// register per cycle; Ready rises once the sweep has finished.
//
// Build option: define REGFILE_BYPASS_EN to forward WriteData to a read port
// that addresses the register being written in the same cycle.

module register_file_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             WriteEnable,
  input  logic [$clog2(DEPTH)-1:0]         RegisterDestination,
  input  logic [WIDTH-1:0]                 WriteData,
  input  logic [NUM_READ*$clog2(DEPTH)-1:0] ReadRegisters,
  output logic [NUM_READ*WIDTH-1:0]        ReadData,
  output logic [NUM_READ-1:0]              ReadBusy,
  input  logic                             AllocEnable,
  input  logic [$clog2(DEPTH)-1:0]         AllocRegister,
  output logic                             Ready
);

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e              state_r;
  state_e              state_s;
  logic [ADDR_W-1:0]   clear_ptr_r;
  logic [ADDR_W-1:0]   clear_ptr_s;
  logic [DEPTH-1:0]    busy_r;
  logic [DEPTH-1:0]    busy_s;
  logic                ready_r;

  // Register 0 is never stored: the array starts at index 1.
  logic [WIDTH-1:0]    mem_r [1:DEPTH-1];

  logic                wr_fire_s;
  logic                alloc_fire_s;
  logic                sweep_fire_s;

  logic [ADDR_W-1:0]   raddr_s;
  logic [NUM_READ*WIDTH-1:0] rdata_s;
  logic [NUM_READ-1:0] rbusy_s;

  // Qualified write/alloc/sweep strobes; nothing architectural happens in CLEAR.
  always_comb begin
    wr_fire_s    = 1'b0;
    alloc_fire_s = 1'b0;
    sweep_fire_s = 1'b0;
    if (state_r == READY) begin
      wr_fire_s    = WriteEnable && (RegisterDestination != ZERO_ADDR);
      alloc_fire_s = AllocEnable && (AllocRegister != ZERO_ADDR);
    end else begin
      sweep_fire_s = (clear_ptr_r != ZERO_ADDR);
    end
  end

  // Next-state logic for the clear sweep: walk 1..DEPTH-1, then become usable.
  always_comb begin
    state_s     = state_r;
    clear_ptr_s = clear_ptr_r;
    case (state_r)
      CLEAR: begin
        clear_ptr_s = clear_ptr_r + ONE_ADDR;
        if (clear_ptr_r == LAST_ADDR) begin
          state_s = READY;
        end else begin
          state_s = CLEAR;
        end
      end
      READY: begin
        state_s     = READY;
        clear_ptr_s = clear_ptr_r;
      end
      default: begin
        state_s     = CLEAR;
        clear_ptr_s = ONE_ADDR;
      end
    endcase
  end

  // State, sweep pointer and Ready flag; reset restarts the sweep from register 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= CLEAR;
      clear_ptr_r <= ONE_ADDR;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      clear_ptr_r <= clear_ptr_s;
      ready_r     <= (state_s == READY);
    end
  end

  // Scoreboard update: writeback clears, allocation sets; allocation applied
  // last so a same-cycle re-allocation keeps the register busy.
  always_comb begin
    busy_s = busy_r;
    case (state_r)
      CLEAR: begin
        busy_s = {DEPTH{1'b0}};
      end
      READY: begin
        if (wr_fire_s) begin
          busy_s[RegisterDestination] = 1'b0;
        end else begin
          busy_s = busy_s;
        end
        if (alloc_fire_s) begin
          busy_s[AllocRegister] = 1'b1;
        end else begin
          busy_s = busy_s;
        end
      end
      default: begin
        busy_s = {DEPTH{1'b0}};
      end
    endcase
    busy_s[0] = 1'b0;
  end

  // Busy bit storage; reset drops every pending producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_s;
    end
  end

  // Register storage: sweep zeroes one entry per cycle, writeback stores data.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Storage is not reset; the sweep that follows clears it.
    end else if (sweep_fire_s) begin
      mem_r[clear_ptr_r] <= {WIDTH{1'b0}};
    end else if (wr_fire_s) begin
      mem_r[RegisterDestination] <= WriteData;
    end
  end

  // Combinational read ports; register 0 and the whole file during CLEAR read
  // as zero and not busy.
  always_comb begin
    rdata_s = {(NUM_READ*WIDTH){1'b0}};
    rbusy_s = {NUM_READ{1'b0}};
    raddr_s = ZERO_ADDR;
    for (int i = 0; i < NUM_READ; i++) begin
      raddr_s = ReadRegisters[i*ADDR_W +: ADDR_W];
      if ((state_r != READY) || (raddr_s == ZERO_ADDR)) begin
        rdata_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        rbusy_s[i]                = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_fire_s && (raddr_s == RegisterDestination)) begin
        // Forward the writeback; only a same-cycle re-allocation keeps it busy.
        rdata_s[i*WIDTH +: WIDTH] = WriteData;
        rbusy_s[i]                = alloc_fire_s && (AllocRegister == raddr_s);
      end
`endif
      else begin
        rdata_s[i*WIDTH +: WIDTH] = mem_r[raddr_s];
        rbusy_s[i]                = busy_r[raddr_s];
      end
    end
  end

  assign ReadData = rdata_s;
  assign ReadBusy = rbusy_s;
  assign Ready    = ready_r;

endmodule
